// File: rtl/seq_monitor_if.sv
// Strobe/result bundle between the sequence stimulus stage (master) and seq_monitor (slave).
// CNT_W must match the CNT_W of the seq_monitor instance it connects to.
interface seq_monitor_if #(
    parameter int CNT_W = 16
);
    logic             A;
    logic             B;
    logic             C;
    logic             J;
    logic             K;
    logic             X;
    logic             MATCH;
    logic             PASS;
    logic             FAIL;
    logic             BUSY;
    logic [CNT_W-1:0] PASS_CNT;
    logic [CNT_W-1:0] FAIL_CNT;

    modport master (
        output A, B, C, J, K, X,
        input  MATCH, PASS, FAIL, BUSY, PASS_CNT, FAIL_CNT
    );

    modport slave (
        input  A, B, C, J, K, X,
        output MATCH, PASS, FAIL, BUSY, PASS_CNT, FAIL_CNT
    );
endinterface

// File: rtl/seq_monitor.sv
// Hardware checker for C ##1 B[*1:B_MAX] ##1 A |=> J[*J_LEN] ##1 K with X as abort.
// Define SEQ_MONITOR_COUNT_EN to build the saturating PASS_CNT/FAIL_CNT counters.
module seq_monitor #(
    parameter int B_MAX = 3,
    parameter int J_LEN = 4,
    parameter int CNT_W = 16
) (
    input logic          CLK,
    input logic          RST,
    seq_monitor_if.slave bus
);

    // B needs one fewer sample than C: the oldest window position must be C, never B.
    logic [B_MAX:1]   bHist;
    logic [B_MAX+1:1] cHist;
    logic [J_LEN+1:1] ob;
    logic [J_LEN+1:1] obNext;
    logic [J_LEN+1:1] failVec;
    logic             bRun;
    logic             match;
    logic             passNow;

    always_comb begin
        match = 1'b0;
        bRun  = 1'b1;
        for (int k = 1; k <= B_MAX; k++) begin
            bRun = bRun & bHist[k];
            if (bRun && cHist[k+1]) begin
                match = 1'b1;
            end
        end
        match = match & bus.A & ~bus.X;
    end

    always_comb begin
        failVec = '0;
        for (int i = 1; i <= J_LEN; i++) begin
            failVec[i] = ob[i] & ~bus.J;
        end
        failVec[J_LEN+1] = ob[J_LEN+1] & ~bus.K;
        if (bus.X) begin
            failVec = '0;
        end
    end

    always_comb begin
        passNow = ob[J_LEN+1] & bus.K & ~bus.X;
        obNext  = '0;
        if (!bus.X) begin
            obNext = {ob[J_LEN:1] & {J_LEN{bus.J}}, match};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bHist     <= '0;
            cHist     <= '0;
            ob        <= '0;
            bus.MATCH <= 1'b0;
            bus.PASS  <= 1'b0;
            bus.FAIL  <= 1'b0;
            bus.BUSY  <= 1'b0;
        end else begin
            if (bus.X) begin
                bHist <= '0;
                cHist <= '0;
            end else begin
                bHist <= (bHist << 1) | B_MAX'(bus.B);
                cHist <= (cHist << 1) | (B_MAX + 1)'(bus.C);
            end
            ob        <= obNext;
            bus.MATCH <= match;
            bus.PASS  <= passNow;
            bus.FAIL  <= |failVec;
            bus.BUSY  <= |obNext;
        end
    end

`ifdef SEQ_MONITOR_COUNT_EN
    localparam int PC_W  = $clog2(J_LEN + 2);
    localparam int SUM_W = CNT_W + PC_W;

    logic [PC_W-1:0]  failCount;
    logic [SUM_W-1:0] failSum;
    logic [CNT_W-1:0] failCntNext;

    // Several attempts at different positions can fail together, so FAIL_CNT adds a popcount.
    always_comb begin
        failCount = '0;
        for (int i = 1; i <= J_LEN + 1; i++) begin
            failCount = failCount + PC_W'(failVec[i]);
        end
        failSum     = SUM_W'(bus.FAIL_CNT) + SUM_W'(failCount);
        failCntNext = failSum[CNT_W-1:0];
        if (failSum > SUM_W'({CNT_W{1'b1}})) begin
            failCntNext = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.PASS_CNT <= '0;
            bus.FAIL_CNT <= '0;
        end else begin
            if (passNow && (bus.PASS_CNT != '1)) begin
                bus.PASS_CNT <= bus.PASS_CNT + 1'b1;
            end
            bus.FAIL_CNT <= failCntNext;
        end
    end
`else
    assign bus.PASS_CNT = '0;
    assign bus.FAIL_CNT = '0;
`endif

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench for seq_monitor: directed cycles push hand-computed expectations,
// a monitor pops one per clock and compares both a default and a CNT_W=2 instance.
module tb_seq_monitor;

    localparam logic [5:0] SA = 6'b000001;
    localparam logic [5:0] SB = 6'b000010;
    localparam logic [5:0] SC = 6'b000100;
    localparam logic [5:0] SJ = 6'b001000;
    localparam logic [5:0] SK = 6'b010000;
    localparam logic [5:0] SX = 6'b100000;
    localparam logic [5:0] S0 = 6'b000000;

    // Expected flag bits in {MATCH, PASS, FAIL, BUSY} order
    localparam logic [3:0] EM = 4'b1000;
    localparam logic [3:0] EP = 4'b0100;
    localparam logic [3:0] EF = 4'b0010;
    localparam logic [3:0] EY = 4'b0001;
    localparam logic [3:0] E0 = 4'b0000;

    typedef struct {
        logic [3:0] flags;
        int         pc;
        int         fc;
        int         spc;
        int         sfc;
        string      name;
    } expRec_t;

    logic    clk;
    logic    rst;
    int      checks;
    int      errors;
    expRec_t expQ[$];

    seq_monitor_if #(.CNT_W(16)) bus ();
    seq_monitor_if #(.CNT_W(2))  satBus ();

    seq_monitor #(.B_MAX(3), .J_LEN(4), .CNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    seq_monitor #(.B_MAX(3), .J_LEN(4), .CNT_W(2)) satDut (
        .CLK (clk),
        .RST (rst),
        .bus (satBus)
    );

    assign satBus.A = bus.A;
    assign satBus.B = bus.B;
    assign satBus.C = bus.C;
    assign satBus.J = bus.J;
    assign satBus.K = bus.K;
    assign satBus.X = bus.X;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counters only exist when the counting feature is compiled in
    function automatic int cntExp(input int v, input int maxV);
`ifdef SEQ_MONITOR_COUNT_EN
        return (v > maxV) ? maxV : v;
`else
        return 0 * v * maxV;
`endif
    endfunction

    task automatic applyStimulus(input logic [5:0] s, input logic r, input logic [3:0] flags,
                                 input int pc, input int fc, input string name);
        expRec_t rec;
        @(negedge clk);
        rst   = r;
        bus.A = s[0];
        bus.B = s[1];
        bus.C = s[2];
        bus.J = s[3];
        bus.K = s[4];
        bus.X = s[5];
        rec.flags = flags;
        rec.pc    = cntExp(pc, 65535);
        rec.fc    = cntExp(fc, 65535);
        rec.spc   = cntExp(pc, 3);
        rec.sfc   = cntExp(fc, 3);
        rec.name  = name;
        expQ.push_back(rec);
    endtask

    task automatic checkOutput(input expRec_t rec);
        logic [3:0] actFlags;
        int         aPc, aFc, aSpc, aSfc;
        actFlags = {bus.MATCH, bus.PASS, bus.FAIL, bus.BUSY};
        aPc  = int'(bus.PASS_CNT);
        aFc  = int'(bus.FAIL_CNT);
        aSpc = int'(satBus.PASS_CNT);
        aSfc = int'(satBus.FAIL_CNT);
        checks++;
        if (actFlags !== rec.flags || aPc != rec.pc || aFc != rec.fc ||
            aSpc != rec.spc || aSfc != rec.sfc) begin
            errors++;
            $display("[TB] FAIL %s: got mpfb=%b pass=%0d fail=%0d satPass=%0d satFail=%0d, expected mpfb=%b pass=%0d fail=%0d satPass=%0d satFail=%0d",
                     rec.name, actFlags, aPc, aFc, aSpc, aSfc,
                     rec.flags, rec.pc, rec.fc, rec.spc, rec.sfc);
        end
    endtask

    // Results of edge n are visible 1 time unit later; the matching record was pushed before edge n
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.A  = 1'b0;
        bus.B  = 1'b0;
        bus.C  = 1'b0;
        bus.J  = 1'b0;
        bus.K  = 1'b0;
        bus.X  = 1'b0;

        // Reset together with X, then a plain reset cycle
        applyStimulus(SX | SJ, 1'b1, E0, 0, 0, "reset with X");
        applyStimulus(S0,      1'b1, E0, 0, 0, "reset");

        // B run without A never matches
        applyStimulus(SC, 1'b0, E0, 0, 0, "t1 C");
        applyStimulus(SB, 1'b0, E0, 0, 0, "t1 B1");
        applyStimulus(SB, 1'b0, E0, 0, 0, "t1 B2");
        applyStimulus(SB, 1'b0, E0, 0, 0, "t1 B3");
        applyStimulus(S0, 1'b0, E0, 0, 0, "t1 idle");

        // Full passing sequence with the longest B run
        applyStimulus(S0, 1'b1, E0, 0, 0, "t2 reset");
        applyStimulus(SC, 1'b0, E0, 0, 0, "t2 C");
        applyStimulus(SB, 1'b0, E0, 0, 0, "t2 B1");
        applyStimulus(SB, 1'b0, E0, 0, 0, "t2 B2");
        applyStimulus(SB, 1'b0, E0, 0, 0, "t2 B3");
        applyStimulus(SA, 1'b0, EM | EY, 0, 0, "t2 A");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(SJ, 1'b0, EY, 0, 0, $sformatf("t2 J%0d", i));
        end
        applyStimulus(SK, 1'b0, EP, 1, 0, "t2 K");
        applyStimulus(S0, 1'b0, E0, 1, 0, "t2 idle");

        // X clears history; counters untouched (no reset here)
        applyStimulus(SC, 1'b0, E0, 1, 0, "t3 C");
        applyStimulus(SB, 1'b0, E0, 1, 0, "t3 B1");
        applyStimulus(SB, 1'b0, E0, 1, 0, "t3 B2");
        applyStimulus(SB, 1'b0, E0, 1, 0, "t3 B3");
        applyStimulus(SX, 1'b0, E0, 1, 0, "t3 X");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(SJ, 1'b0, E0, 1, 0, $sformatf("t3 J%0d", i));
        end
        applyStimulus(S0, 1'b0, E0, 1, 0, "t3 idle");
        applyStimulus(SK, 1'b0, E0, 1, 0, "t3 K");

        // X on a B sample wipes the window that would otherwise match at A
        applyStimulus(SC,      1'b0, E0, 1, 0, "t3b C");
        applyStimulus(SB,      1'b0, E0, 1, 0, "t3b B");
        applyStimulus(SB | SX, 1'b0, E0, 1, 0, "t3b BX");
        applyStimulus(SA,      1'b0, E0, 1, 0, "t3b A");

        // X mid-attempt drops it without a failure
        applyStimulus(SC, 1'b0, E0,      1, 0, "t3c C");
        applyStimulus(SB, 1'b0, E0,      1, 0, "t3c B");
        applyStimulus(SA, 1'b0, EM | EY, 1, 0, "t3c A");
        applyStimulus(SJ, 1'b0, EY,      1, 0, "t3c J1");
        applyStimulus(SX, 1'b0, E0,      1, 0, "t3c X");
        applyStimulus(SJ, 1'b0, E0,      1, 0, "t3c J");
        applyStimulus(SK, 1'b0, E0,      1, 0, "t3c K");

        // Missing K
        applyStimulus(S0, 1'b1, E0, 0, 0, "t4 reset");
        applyStimulus(SC, 1'b0, E0, 0, 0, "t4 C");
        applyStimulus(SB, 1'b0, E0, 0, 0, "t4 B");
        applyStimulus(SA, 1'b0, EM | EY, 0, 0, "t4 A");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(SJ, 1'b0, EY, 0, 0, $sformatf("t4 J%0d", i));
        end
        applyStimulus(S0, 1'b0, EF, 0, 1, "t4 no K");
        applyStimulus(SK, 1'b0, E0, 0, 1, "t4 late K");

        // Three overlapping antecedents
        applyStimulus(S0,      1'b1, E0,           0, 0, "t5 reset");
        applyStimulus(SC,      1'b0, E0,           0, 0, "t5 C");
        applyStimulus(SB,      1'b0, E0,           0, 0, "t5 B");
        applyStimulus(SB | SA, 1'b0, EM | EY,      0, 0, "t5 BA1");
        applyStimulus(SB | SA, 1'b0, EM | EF | EY, 0, 1, "t5 BA2");
        applyStimulus(SA,      1'b0, EM | EF | EY, 0, 2, "t5 A");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(SJ, 1'b0, EY, 0, 2, $sformatf("t5 J%0d", i));
        end
        applyStimulus(SK, 1'b0, EP, 1, 2, "t5 K");
        applyStimulus(S0, 1'b0, E0, 1, 2, "t5 idle");

        // Two attempts failing on the same sample count twice
        applyStimulus(S0,           1'b1, E0,      0, 0, "t6 reset");
        applyStimulus(SC,           1'b0, E0,      0, 0, "t6 C");
        applyStimulus(SB,           1'b0, E0,      0, 0, "t6 B");
        applyStimulus(SB | SA,      1'b0, EM | EY, 0, 0, "t6 BA");
        applyStimulus(SB | SA | SJ, 1'b0, EM | EY, 0, 0, "t6 BAJ");
        applyStimulus(S0,           1'b0, EF,      0, 2, "t6 double fail");

        // New antecedent completing on the K sample of an earlier attempt
        applyStimulus(S0,      1'b1, E0,           0, 0, "t7 reset");
        applyStimulus(SC,      1'b0, E0,           0, 0, "t7 C");
        applyStimulus(SB,      1'b0, E0,           0, 0, "t7 B");
        applyStimulus(SA,      1'b0, EM | EY,      0, 0, "t7 A");
        applyStimulus(SJ,      1'b0, EY,           0, 0, "t7 J1");
        applyStimulus(SJ,      1'b0, EY,           0, 0, "t7 J2");
        applyStimulus(SJ | SC, 1'b0, EY,           0, 0, "t7 J3C");
        applyStimulus(SJ | SB, 1'b0, EY,           0, 0, "t7 J4B");
        applyStimulus(SK | SA, 1'b0, EM | EP | EY, 1, 0, "t7 KA");
        applyStimulus(S0,      1'b0, EF,           1, 1, "t7 idle");

        // Reset on the third J discards the attempt
        applyStimulus(S0, 1'b1, E0,      0, 0, "t8 reset");
        applyStimulus(SC, 1'b0, E0,      0, 0, "t8 C");
        applyStimulus(SB, 1'b0, E0,      0, 0, "t8 B");
        applyStimulus(SA, 1'b0, EM | EY, 0, 0, "t8 A");
        applyStimulus(SJ, 1'b0, EY,      0, 0, "t8 J1");
        applyStimulus(SJ, 1'b0, EY,      0, 0, "t8 J2");
        applyStimulus(SJ, 1'b1, E0,      0, 0, "t8 J3 reset");
        applyStimulus(SJ, 1'b0, E0,      0, 0, "t8 J4");
        applyStimulus(SK, 1'b0, E0,      0, 0, "t8 K");

        // Five passes: wide counter reaches 5, the 2-bit one holds at 3
        applyStimulus(S0, 1'b1, E0, 0, 0, "t9 reset");
        for (int n = 1; n <= 5; n++) begin
            applyStimulus(SC, 1'b0, E0,      n - 1, 0, $sformatf("t9 C #%0d", n));
            applyStimulus(SB, 1'b0, E0,      n - 1, 0, $sformatf("t9 B #%0d", n));
            applyStimulus(SA, 1'b0, EM | EY, n - 1, 0, $sformatf("t9 A #%0d", n));
            for (int i = 1; i <= 4; i++) begin
                applyStimulus(SJ, 1'b0, EY, n - 1, 0, $sformatf("t9 J%0d #%0d", i, n));
            end
            applyStimulus(SK, 1'b0, EP, n, 0, $sformatf("t9 K #%0d", n));
        end
        applyStimulus(S0, 1'b0, E0, 5, 0, "t9 idle");

        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        checks++;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d records left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_monitor.md
# seq_monitor

Synthesizable sequence monitor that consumes the A/B/C/J/K/X control strobes produced by the sequence stimulus stage and checks, in hardware, the protocol rule C ##1 B[*1:B_MAX] ##1 A |=> J[*J_LEN] ##1 K, with X as an abort. It tracks every overlapping attempt concurrently. It reports per-attempt pass/fail pulses, and optionally keeps pass/fail counts, so the check survives into emulation and silicon where the simulation-only property does not.

## Interface
- B_MAX, 3: maximum B run length accepted in the antecedent (1..B_MAX)
- J_LEN, 4: number of consecutive J cycles required in the consequent
- CNT_W, 16: width of pass/fail counters
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- A, B, C, J, K  input  1 each  protocol strobes, sampled every rising CLK edge
- X  input  1  abort/disable; clears all history and in-flight attempts
- MATCH  output  1  registered; antecedent completed on previous sample
- PASS  output  1  registered; one or more attempts completed with K
- FAIL  output  1  registered; one or more attempts violated the consequent
- BUSY  output  1  registered; any attempt in flight
- PASS_CNT  output  CNT_W  passing attempts, saturating
- FAIL_CNT  output  CNT_W  failing attempts, saturating

## Operation
- History: shift registers hold the last B_MAX+1 samples of B and C (index 1 = previous cycle).
- Antecedent match at current sample: A & OR over k=1..B_MAX of (B[1..k] all high & C[k+1]).
- Obligation vector OB[1..J_LEN+1], one bit per consequent position. OB[i] set means the current sample is position i of some attempt.
- Position i <= J_LEN requires J; position J_LEN+1 requires K.
- Next state: OB[1] <= match. OB[i+1] <= OB[i] & J for i <= J_LEN.
- OB[i] & ~required-signal counts as one failure. OB[J_LEN+1] & K counts as one pass.
- Several attempts may be in flight at once, at most one per position. Each attempt is judged independently.
- Failures in one cycle may number up to J_LEN+1. FAIL_CNT adds that popcount; FAIL is the OR.
- X high on a sample:
  - clears B/C history and OB;
  - forces no match, no pass, no fail for that sample;
  - leaves counters unchanged.
- BUSY = |OB after update.
- Counters saturate at all-ones and never wrap.
- An attempt can only start after its antecedent completes. A B run longer than B_MAX before A produces no match unless a shorter window also begins with C.

## Timing
- Reset: every register, history bit and OB bit is cleared. MATCH, PASS, FAIL, BUSY, PASS_CNT and FAIL_CNT are 0 in the cycle after RST is sampled high.
- Reset mid-attempt: the attempt is discarded and no pass/fail is reported for it.
- Latency: a decision made on edge n appears on MATCH/PASS/FAIL after edge n, for exactly one cycle. Counters reflect it after the same edge.
- First J is checked on the sample after A (non-overlapping implication). K is checked J_LEN+1 samples after A.
- Antecedent completing on the same sample as K of an earlier attempt: both are evaluated in the same cycle.
- Simultaneous X and RST: RST wins; the results are identical.

## Configuration
- SEQ_MONITOR_COUNT_EN defined: PASS_CNT/FAIL_CNT counters and the popcount adder are built.
- SEQ_MONITOR_COUNT_EN undefined: PASS_CNT and FAIL_CNT are tied to 0 and no counter logic is built. PASS, FAIL, MATCH and BUSY are unchanged.

## Test plan
Defaults apply. Each semicolon advances one cycle; t0 is the first sample.
- "C;B;B;B" -> MATCH, PASS, FAIL never asserted; counters stay 0.
- "C;B;B;B;A;J;J;J;J;K":
  - MATCH pulses after the A sample;
  - PASS pulses once after the K sample;
  - PASS_CNT=1, FAIL_CNT=0;
  - BUSY high for 5 cycles.
- "C;B;B;B;X;J;J;J;J;;K" -> X clears history; no MATCH, PASS or FAIL; counters unchanged.
- "C;B;A;J;J;J;J;;K" -> FAIL pulses once after the empty sample at t7 (K missing); FAIL_CNT=1, PASS_CNT=0.
- "C;B;BA;BA;A;J;J;J;J;K;" -> three overlapping matches at t2, t3, t4:
  - FAIL after t3 (attempt 1) and after t4 (attempt 2);
  - PASS after t9 (attempt 3);
  - FAIL_CNT=2, PASS_CNT=1.
- Reset and saturation:
  - Assert RST on the third J of a passing sequence -> no PASS follows and all outputs are 0.
  - With CNT_W=2, run 5 passing sequences -> PASS_CNT holds at 3.
